// File: rtl/fixed_mac.sv
// fixed_mac: pipelined signed Q(INT_W).(FRAC_W) multiply-accumulate, rounded and saturated per group.
// Latency 2 cycles from last beat to out_valid; a held result (out_valid && !out_ready) freezes the pipe.
module fixed_mac #(
   parameter int INT_W     = 8,
   parameter int FRAC_W    = 8,
   parameter int ACC_GUARD = 4,
   parameter int ROUND     = 1,
   localparam int NUM_W    = INT_W + FRAC_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [NUM_W-1:0] in_a,
   input  logic signed [NUM_W-1:0] in_b,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [NUM_W-1:0] out_data,
   output logic                    out_sat
);
   localparam int P_W   = 2 * NUM_W;
   localparam int Q_W   = P_W - FRAC_W;
   localparam int ACC_W = Q_W + ACC_GUARD;

   localparam logic [P_W-1:0] RND = (ROUND != 0) ? (P_W'(1) << (FRAC_W - 1)) : '0;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] LIM_MAX = {{(ACC_W-NUM_W+1){1'b0}}, {(NUM_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] LIM_MIN = {{(ACC_W-NUM_W+1){1'b1}}, {(NUM_W-1){1'b0}}};
   localparam logic signed [NUM_W-1:0] RES_MAX = {1'b0, {(NUM_W-1){1'b1}}};
   localparam logic signed [NUM_W-1:0] RES_MIN = {1'b1, {(NUM_W-1){1'b0}}};

   typedef struct packed {
      logic                  vld;
      logic                  last;
      logic signed [P_W-1:0] p;
   } s1_t;

   s1_t                     s1;
   logic                    stall;
   logic                    accept;
   logic signed [P_W-1:0]   prod;
   logic signed [P_W-1:0]   p_rnd;
   logic signed [Q_W-1:0]   q;
   logic signed [ACC_W:0]   sum_w;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc;
   logic signed [NUM_W-1:0] res;
   logic                    grp_sat;
   logic                    acc_clamp;
   logic                    out_clamp;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   // full-width product of two NUM_W signed values cannot overflow P_W
   assign prod = P_W'(in_a) * P_W'(in_b);

   always_comb begin
      p_rnd = s1.p + $signed(RND);
      q     = Q_W'(p_rnd >>> FRAC_W);
      // one extra bit so an accumulator overflow is visible before clamping
      sum_w = {acc[ACC_W-1], acc} + {{(ACC_W+1-Q_W){q[Q_W-1]}}, q};
      acc_clamp = (sum_w[ACC_W] != sum_w[ACC_W-1]);
      if (acc_clamp) begin
         sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum = sum_w[ACC_W-1:0];
      end
      out_clamp = 1'b0;
      res       = sum[NUM_W-1:0];
      if (sum > LIM_MAX) begin
         res       = RES_MAX;
         out_clamp = 1'b1;
      end else if (sum < LIM_MIN) begin
         res       = RES_MIN;
         out_clamp = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= '0;
         acc       <= '0;
         grp_sat   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (!stall) begin
         s1.vld <= accept;
         if (accept) begin
            s1.last <= in_last;
            s1.p    <= prod;
         end
         out_valid <= s1.vld && s1.last;
         if (s1.vld) begin
            if (s1.last) begin
               out_data <= res;
               out_sat  <= grp_sat | acc_clamp | out_clamp;
               acc      <= '0;
               grp_sat  <= 1'b0;
            end else begin
               acc     <= sum;
               grp_sat <= grp_sat | acc_clamp;
            end
         end
      end
   end

endmodule
